// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: chip-enable and reset levels,
// instruction address bus width and FSM state encoding.
package pc_gen_pkg;

   localparam int   INST_ADDR_BUS_W = 32;
   localparam logic CHIP_ENABLE     = 1'b1;
   localparam logic CHIP_DISABLE    = 1'b0;
   localparam logic RST_ENABLE      = 1'b0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } pc_state_t;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the pipeline and the PC generator.
// The master side is the PC generator; the slave side is the pipeline/fetch logic.
interface pc_gen_if
   import pc_gen_pkg::*;
#(
   parameter int ADDR_W = INST_ADDR_BUS_W
) ();

   logic              stall;
   logic              imem_ready;
   logic              branch_flag;
   logic [ADDR_W-1:0] branch_target;
   logic              flush;
   logic [ADDR_W-1:0] new_pc;
   logic [ADDR_W-1:0] pc;
   logic              ce;
   logic              misalign;
   logic [ADDR_W-1:0] misalign_addr;

   modport master (
      input  stall, imem_ready, branch_flag, branch_target, flush, new_pc,
      output pc, ce, misalign, misalign_addr
   );

   modport slave (
      output stall, imem_ready, branch_flag, branch_target, flush, new_pc,
      input  pc, ce, misalign, misalign_addr
   );

endinterface

// File: rtl/pc_gen_redirect_buf.sv
// Single-entry pending-redirect store: holds a branch target seen while fetch is held.
// Clear wins over capture; capture wins over consume (never both in one cycle).
module pc_redirect_buf
   import pc_gen_pkg::*;
#(
   parameter int ADDR_W = INST_ADDR_BUS_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic              consume,
   input  logic              clear,
   input  logic [ADDR_W-1:0] target_in,
   output logic              vld,
   output logic [ADDR_W-1:0] target
);

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         vld    <= 1'b0;
         target <= '0;
      end else if (clear) begin
         vld    <= 1'b0;
      end else if (capture) begin
         vld    <= 1'b1;
         target <= target_in;
      end else if (consume) begin
         vld    <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with flush/hold/branch/pending-redirect priority.
// Optional target alignment check enabled by defining PC_MISALIGN_CHECK_EN.
//
// state   | meaning
// ST_IDLE | in or just out of reset, ce=0, inputs ignored
// ST_RUN  | fetching, ce=1, pc advances or redirects each free edge
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                ADDR_W       = INST_ADDR_BUS_W,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter int                INST_BYTES   = 4
) (
   input  logic     clk,
   input  logic     rst,
   pc_gen_if.master bus
);

   localparam logic [ADDR_W-1:0] INC = ADDR_W'(INST_BYTES);

   pc_state_t         state;
   logic              run;
   logic              hold;
   logic              redirect;
   logic              redir_bad;
   logic              pend_vld;
   logic [ADDR_W-1:0] pend_target;
   logic [ADDR_W-1:0] redir_target;

   assign run          = (state == ST_RUN);
   assign hold         = bus.stall | ~bus.imem_ready;
   assign redirect     = ~hold & (bus.branch_flag | pend_vld);
   assign redir_target = bus.branch_flag ? bus.branch_target : pend_target;

   pc_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
      .clk       (clk),
      .rst       (rst),
      .capture   (run & ~bus.flush & hold & bus.branch_flag),
      .consume   (run & ~bus.flush & redirect),
      .clear     (run & bus.flush),
      .target_in (bus.branch_target),
      .vld       (pend_vld),
      .target    (pend_target)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         state  <= ST_IDLE;
         bus.pc <= RESET_VECTOR;
         bus.ce <= CHIP_DISABLE;
      end else begin
         case (state)
            ST_IDLE: begin
               // pc stays at RESET_VECTOR so it is the first address fetched
               state  <= ST_RUN;
               bus.ce <= CHIP_ENABLE;
            end
            ST_RUN: begin
               if (bus.flush) begin
                  bus.pc <= bus.new_pc;
               end else if (hold) begin
                  bus.pc <= bus.pc;
               end else if (redirect) begin
                  if (!redir_bad) bus.pc <= redir_target;
               end else begin
                  bus.pc <= bus.pc + INC;
               end
            end
            default: begin
               state  <= ST_IDLE;
               bus.ce <= CHIP_DISABLE;
            end
         endcase
      end
   end

`ifdef PC_MISALIGN_CHECK_EN
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

   assign redir_bad = |(redir_target & ALIGN_MASK);

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         bus.misalign      <= 1'b0;
         bus.misalign_addr <= '0;
      end else begin
         bus.misalign <= run & ~bus.flush & redirect & redir_bad;
         if (run & ~bus.flush & redirect & redir_bad) bus.misalign_addr <= redir_target;
      end
   end
`else
   assign redir_bad         = 1'b0;
   assign bus.misalign      = 1'b0;
   assign bus.misalign_addr = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random traffic,
// all compared against a behavioural model of the fetch-address rules.
module tb_pc_gen;
   import pc_gen_pkg::*;

   localparam int          AW = 32;
   localparam logic [31:0] RV = 32'h0;
   localparam int          IB = 4;
`ifdef PC_MISALIGN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pc_gen_if #(.ADDR_W(AW)) bus ();

   pc_gen #(.ADDR_W(AW), .RESET_VECTOR(RV), .INST_BYTES(IB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   bit          m_run;
   bit          m_pv;
   bit          m_mis;
   logic [31:0] m_pc;
   logic [31:0] m_pt;
   logic [31:0] m_maddr;
   int          n_assert = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_pv = 1'b0; m_mis = 1'b0;
      m_pc = RV; m_pt = '0; m_maddr = '0;
   endtask

   task automatic model_load(input logic [31:0] t);
      if (CHK && (t % IB) != 0) begin
         m_mis = 1'b1;
         m_maddr = t;
      end else begin
         m_pc = t;
      end
   endtask

   // Apply the fetch-address rules to the inputs present just before an edge.
   task automatic model_edge();
      m_mis = 1'b0;
      if (!m_run) m_run = 1'b1;
      else if (bus.flush) begin
         m_pc = bus.new_pc; m_pv = 1'b0;
      end else if (bus.stall || !bus.imem_ready) begin
         if (bus.branch_flag) begin m_pv = 1'b1; m_pt = bus.branch_target; end
      end else if (bus.branch_flag) begin
         model_load(bus.branch_target); m_pv = 1'b0;
      end else if (m_pv) begin
         model_load(m_pt); m_pv = 1'b0;
      end else m_pc = m_pc + IB;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_pc"}, bus.pc, m_pc);
      check({tag, "_ce"}, 32'(bus.ce), 32'(m_run));
      check({tag, "_mis"}, 32'(bus.misalign), 32'(m_mis));
      check({tag, "_maddr"}, bus.misalign_addr, m_maddr);
   endtask

   task automatic drive(input logic st, input logic rdy, input logic bf, input logic [31:0] bt,
                        input logic fl, input logic [31:0] np);
      bus.stall = st; bus.imem_ready = rdy; bus.branch_flag = bf;
      bus.branch_target = bt; bus.flush = fl; bus.new_pc = np;
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [31:0] t;
      logic [31:0] pc_before;
      rst = 1'b0;
      drive(0, 1, 0, 0, 0, 0);
      model_reset();
      #12;
      check_all("reset");
      // branch/flush during reset must be ignored
      drive(0, 1, 1, 32'h300, 1, 32'h500);
      @(posedge clk); #1;
      check_all("reset_ign");
      @(negedge clk) rst = 1'b1;
      drive(0, 1, 0, 0, 0, 0);
      cycle("boot_e1");
      check("boot_e1_pc0", bus.pc, 32'h0);
      cycle("boot_e2");
      check("boot_e2_pc4", bus.pc, 32'h4);
      cycle("boot_e3");
      check("boot_e3_pc8", bus.pc, 32'h8);

      drive(0, 1, 0, 0, 1, 32'h100); cycle("go100");
      drive(1, 1, 1, 32'h400, 0, 0); cycle("stall_cap");
      drive(1, 1, 0, 0, 0, 0);       cycle("stall_1");
      cycle("stall_2");
      check("stall_hold", bus.pc, 32'h100);
      drive(0, 1, 0, 0, 0, 0);       cycle("pend_apply");
      check("pend_400", bus.pc, 32'h400);
      cycle("after_pend");
      check("seq_404", bus.pc, 32'h404);

      drive(1, 1, 1, 32'h400, 1, 32'h180); cycle("flush_prio");
      check("flush_180", bus.pc, 32'h180);
      drive(0, 1, 0, 0, 0, 0);             cycle("flush_clr");
      check("flush_184", bus.pc, 32'h184);

      // two captures while imem not ready: the later one wins
      drive(0, 0, 1, 32'h500, 0, 0); cycle("rdy_cap1");
      drive(0, 0, 1, 32'h600, 0, 0); cycle("rdy_cap2");
      drive(0, 1, 0, 0, 0, 0);       cycle("rdy_apply");
      check("overwrite_600", bus.pc, 32'h600);

      pc_before = bus.pc;
      drive(0, 1, 1, 32'h402, 0, 0); cycle("mis_br");
      check("mis_pc", bus.pc, CHK ? pc_before : 32'h402);
      check("mis_flag", 32'(bus.misalign), CHK ? 32'd1 : 32'd0);
      check("mis_addr", bus.misalign_addr, CHK ? 32'h402 : 32'h0);
      drive(0, 1, 0, 0, 0, 0);       cycle("mis_after");

      drive(0, 1, 0, 0, 1, 32'hFFFF_FFF8); cycle("wrap_a");
      drive(0, 1, 0, 0, 0, 0);             cycle("wrap_b");
      check("wrap_top", bus.pc, 32'hFFFF_FFFC);
      cycle("wrap_c");
      check("wrap_zero", bus.pc, 32'h0);
      check("wrap_nomis", 32'(bus.misalign), 32'd0);

      drive(1, 1, 1, 32'h700, 0, 0); cycle("arst_cap");
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("arst_pc", bus.pc, RV);
      check("arst_ce", 32'(bus.ce), 32'd0);
      check_all("arst");
      drive(0, 1, 0, 0, 0, 0);
      @(negedge clk) rst = 1'b1;
      cycle("arst_e1");
      cycle("arst_e2");
      check("arst_nopend", bus.pc, RV + 32'h4);

      for (int i = 0; i < 400; i++) begin
         t = $urandom;
         if ($urandom_range(3) != 0) t[1:0] = 2'b00;
         drive($urandom_range(9) < 3, $urandom_range(9) < 8, $urandom_range(9) < 2, t,
               $urandom_range(19) == 0, {$urandom} & 32'hFFFF_FFFC);
         cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the PC and all target bus widths in bits.
REQ-002 Parameter RESET_VECTOR, default 0, SHALL set the PC value loaded at reset and used for the first fetch.
REQ-003 Parameter INST_BYTES, default 4, SHALL set the sequential increment in bytes (power of two).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset; asynchronous, active-low.
REQ-006 stall  input  1  SHALL be the pipeline stall request; 1 holds the PC.
REQ-007 imem_ready  input  1  SHALL be the instruction-memory ready; 0 holds the PC.
REQ-008 branch_flag  input  1  SHALL be the branch/jump redirect valid, single-cycle pulse.
REQ-009 branch_target  input  ADDR_W  SHALL be the redirect address, qualified by branch_flag.
REQ-010 flush  input  1  SHALL be the exception flush request.
REQ-011 new_pc  input  ADDR_W  SHALL be the exception handler address, qualified by flush.
REQ-012 pc  output  ADDR_W  SHALL be the current fetch address (registered).
REQ-013 ce  output  1  SHALL be the instruction-memory chip enable (registered).
REQ-014 misalign  output  1  SHALL be the misaligned-target pulse (see Configuration).
REQ-015 misalign_addr  output  ADDR_W  SHALL be the last rejected target (see Configuration).

Function
REQ-016 Two-state FSM SHALL be used: IDLE (ce=0) and RUN (ce=1); IDLE->RUN on the first rising edge after rst deasserts; RUN->IDLE only by reset.
REQ-017 IDLE->RUN edge SHALL keep pc=RESET_VECTOR, so the first fetched address is RESET_VECTOR.
REQ-018 In RUN, per edge, the priority SHALL be: flush > hold (stall|!imem_ready) > branch_flag > pending redirect > sequential.
REQ-019 flush SHALL load pc=new_pc and clear any pending redirect, regardless of stall, imem_ready or branch_flag.
REQ-020 Hold SHALL keep pc unchanged; a branch_flag arriving during hold SHALL be captured into the pending register (pending_vld=1, pending_target=branch_target); a later capture SHALL overwrite an earlier one.
REQ-021 Without hold, branch_flag SHALL load pc=branch_target and clear pending_vld.
REQ-022 Without hold or branch_flag, pending_vld=1 SHALL load pc=pending_target and clear pending_vld.
REQ-023 Otherwise pc SHALL become pc+INST_BYTES, modulo 2^ADDR_W (wraps from all-ones to 0 with no flag).
REQ-024 Redirect latency SHALL be one edge: the pc value after the accepting edge equals the target.
REQ-025 In IDLE all inputs SHALL be ignored.

Reset
REQ-026 Asserting rst SHALL immediately force pc=RESET_VECTOR, ce=0, state=IDLE, pending_vld=0, misalign=0, misalign_addr=0, including mid-stall or with a redirect pending.

Configuration
REQ-027 Macro PC_MISALIGN_CHECK_EN defined: a branch_target or pending_target with any of the low log2(INST_BYTES) bits set SHALL NOT be loaded; pc holds, misalign pulses 1 for one cycle, misalign_addr latches the target, and pending_vld clears. Flush targets are never checked.
REQ-028 Macro PC_MISALIGN_CHECK_EN undefined: targets SHALL be loaded verbatim; misalign and misalign_addr are tied to 0.

Structure
REQ-029 ChipEnable/ChipDisable, RstEnable (active-low value) and InstAddrBus width constants SHALL live in the shared defines package; no local redefinition is permitted.
REQ-030 Pending-redirect storage SHALL be a sub-module pc_redirect_buf (capture, overwrite, consume, clear); everything else is inline.

Verification
REQ-031 rst low then released, no stall -> ce=0 in reset; edge 1: ce=1, pc=0; edges 2,3: pc=4, 8.
REQ-032 RESET_VECTOR=32'hBFC00000, ADDR_W=32, pc reaches 32'hFFFFFFFC -> next edge pc=0, misalign=0.
REQ-033 Running at pc=0x100, stall=1, branch_flag pulse target 0x400, stall released 3 cycles later -> pc holds 0x100 during stall, then 0x400 on the first free edge, then 0x404.
REQ-034 Same cycle flush=1 (new_pc=0x180), branch_flag=1 (0x400), stall=1 -> pc=0x180, pending cleared, next free edge pc=0x184.
REQ-035 PC_MISALIGN_CHECK_EN defined, branch_target=0x402 -> pc holds, misalign=1 for one cycle, misalign_addr=0x402; undefined -> pc=0x402, misalign=0.
REQ-036 rst asserted asynchronously mid-cycle while pending_vld=1 -> pc=RESET_VECTOR and ce=0 before the next edge; after release, no pending target is applied.
